// File: rtl/wb_sram_pkg.sv
// Shared types for the Wishbone SRAM bank controller.
// Optional bank watchdog is enabled by defining WB_SRAM_TIMEOUT_EN.
package wb_sram_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        ERR_NONE    = 2'd0,
        ERR_RANGE   = 2'd1,
        ERR_TIMEOUT = 2'd2
    } err_cause_e;

    function automatic int idx_w(input int n_banks);
        return (n_banks > 1) ? $clog2(n_banks) : 1;
    endfunction

endpackage

// File: rtl/wb_sram_bank_ctrl_watchdog.sv
// BUSY-cycle watchdog for the SRAM bank controller.
// Instantiated only when WB_SRAM_TIMEOUT_EN is defined.
module wb_sram_watchdog
    import wb_sram_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic run,
    output logic expire
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] cnt_q;

    // expire marks the BUSY cycle that brings the count to TIMEOUT_CYCLES
    assign expire = run && (cnt_q == CW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (run && !expire) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/wb_sram_bank_ctrl.sv
// Wishbone-classic slave fronting N_BANKS SRAM macros, one request at a time.
// Define WB_SRAM_TIMEOUT_EN to abort hung banks after TIMEOUT_CYCLES.
module wb_sram_bank_ctrl
    import wb_sram_pkg::*;
#(
    parameter int N_BANKS        = 3,
    parameter int BANK_AW        = 16,
    parameter int DW             = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  wb_clk_i,
    input  logic                  wb_rst_ni,
    input  logic                  wbs_stb_i,
    input  logic                  wbs_cyc_i,
    input  logic                  wbs_we_i,
    input  logic [DW/8-1:0]       wbs_sel_i,
    input  logic [DW-1:0]         wbs_dat_i,
    input  logic [31:0]           wbs_adr_i,
    output logic                  wbs_ack_o,
    output logic                  wbs_err_o,
    output logic [DW-1:0]         wbs_dat_o,
    output logic [N_BANKS-1:0]    bank_stb_o,
    output logic                  bank_cyc_o,
    output logic                  bank_we_o,
    output logic [DW/8-1:0]       bank_sel_o,
    output logic [DW-1:0]         bank_dat_o,
    output logic [BANK_AW-1:0]    bank_adr_o,
    input  logic [N_BANKS-1:0]    bank_ack_i,
    input  logic [N_BANKS*DW-1:0] bank_dat_i,
    output logic                  err_irq_o
);

    localparam int IDX_W = idx_w(N_BANKS);

    state_e             state_q;
    state_e             state_d;
    err_cause_e         cause;
    logic [IDX_W-1:0]   idx_in;
    logic [IDX_W-1:0]   idx_q;
    logic               in_range;
    logic               req;
    logic               load;
    logic               sel_ack;
    logic               wd_expire;
    logic               ack_d;
    logic               err_d;
    logic [DW-1:0]      rd_word;
    logic [DW-1:0]      rsp_dat_d;
    logic [N_BANKS-1:0] stb_d;

    assign idx_in   = wbs_adr_i[BANK_AW +: IDX_W];
    assign in_range = {1'b0, idx_in} < (IDX_W + 1)'(N_BANKS);
    assign req      = wbs_stb_i & wbs_cyc_i;
    assign sel_ack  = bank_ack_i[idx_q];
    assign rd_word  = bank_dat_i[idx_q*DW +: DW];

    // address bits above the bank index alias onto the same banks
    generate
        if (BANK_AW + IDX_W < 32) begin : g_alias
            logic unused_adr;
            assign unused_adr = ^wbs_adr_i[31:BANK_AW+IDX_W];
        end
    endgenerate

`ifdef WB_SRAM_TIMEOUT_EN
    wb_sram_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_wdog (
        .clk   (wb_clk_i),
        .rst_n (wb_rst_ni),
        .clr   (load),
        .run   (state_q == ST_BUSY),
        .expire(wd_expire)
    );
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT_CYCLES > 0);
    assign wd_expire      = 1'b0;
`endif

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        load      = 1'b0;
        cause     = ERR_NONE;
        stb_d     = '0;
        rsp_dat_d = wbs_dat_o;
        unique case (state_q)
            ST_IDLE: begin
                if (req) begin
                    load = 1'b1;
                    if (in_range) begin
                        state_d = ST_BUSY;
                        stb_d   = N_BANKS'(1) << idx_in;
                    end else begin
                        state_d   = ST_RESP;
                        cause     = ERR_RANGE;
                        rsp_dat_d = '0;
                    end
                end
            end
            ST_BUSY: begin
                // host abort beats a same-cycle ack or timeout
                if (!wbs_cyc_i) begin
                    state_d = ST_IDLE;
                end else if (sel_ack) begin
                    state_d   = ST_RESP;
                    rsp_dat_d = bank_we_o ? '0 : rd_word;
                end else if (wd_expire) begin
                    state_d   = ST_RESP;
                    cause     = ERR_TIMEOUT;
                    rsp_dat_d = '0;
                end else begin
                    stb_d = bank_stb_o;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign err_d = (cause != ERR_NONE);
    assign ack_d = (state_d == ST_RESP) && !err_d;

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            idx_q      <= '0;
            bank_adr_o <= '0;
            bank_dat_o <= '0;
            bank_sel_o <= '0;
            bank_we_o  <= 1'b0;
            bank_stb_o <= '0;
            bank_cyc_o <= 1'b0;
            wbs_ack_o  <= 1'b0;
            wbs_err_o  <= 1'b0;
            err_irq_o  <= 1'b0;
            wbs_dat_o  <= '0;
        end else begin
            if (load) begin
                idx_q      <= idx_in;
                bank_adr_o <= wbs_adr_i[BANK_AW-1:0];
                bank_dat_o <= wbs_dat_i;
                bank_sel_o <= wbs_sel_i;
                bank_we_o  <= wbs_we_i;
            end
            bank_stb_o <= stb_d;
            bank_cyc_o <= (state_d == ST_BUSY);
            wbs_ack_o  <= ack_d;
            wbs_err_o  <= err_d;
            err_irq_o  <= err_d;
            wbs_dat_o  <= rsp_dat_d;
        end
    end

endmodule

// File: tb/tb_wb_sram_bank_ctrl.sv
// Bench for wb_sram_bank_ctrl: transaction-level reference model with a
// per-cycle compare process, directed corner cases and random traffic.
module tb_wb_sram_bank_ctrl;

    localparam int NB = 3;
    localparam int AW = 16;
    localparam int IW = 2;
`ifdef WB_SRAM_TIMEOUT_EN
    localparam int TO = 8;
`else
    localparam int TO = 0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          stb, cyc, we;
    logic [3:0]    sel;
    logic [31:0]   wdat, adr;
    logic          ack, err, irq;
    logic [31:0]   rdat;
    logic [NB-1:0] b_stb;
    logic          b_cyc, b_we;
    logic [3:0]    b_sel;
    logic [31:0]   b_dat;
    logic [AW-1:0] b_adr;
    logic [NB-1:0] b_ack;
    logic [95:0]   b_rdat;

    always #5 clk = ~clk;

    wb_sram_bank_ctrl #(
        .N_BANKS(NB), .BANK_AW(AW), .DW(32), .TIMEOUT_CYCLES(8)
    ) dut (
        .wb_clk_i(clk), .wb_rst_ni(rst_n),
        .wbs_stb_i(stb), .wbs_cyc_i(cyc), .wbs_we_i(we),
        .wbs_sel_i(sel), .wbs_dat_i(wdat), .wbs_adr_i(adr),
        .wbs_ack_o(ack), .wbs_err_o(err), .wbs_dat_o(rdat),
        .bank_stb_o(b_stb), .bank_cyc_o(b_cyc), .bank_we_o(b_we),
        .bank_sel_o(b_sel), .bank_dat_o(b_dat), .bank_adr_o(b_adr),
        .bank_ack_i(b_ack), .bank_dat_i(b_rdat), .err_irq_o(irq)
    );

    int n_vec = 0;
    int n_bad = 0;

    logic          chk_en = 1'b0;
    logic [NB-1:0] exp_stb = '0;
    logic          exp_cyc = 1'b0, exp_ack = 1'b0, exp_err = 1'b0;
    logic [31:0]   exp_dat = '0;
    logic [15:0]   exp_badr = '0;
    logic [31:0]   exp_bdat = '0;
    logic [3:0]    exp_bsel = '0;
    logic          exp_bwe = 1'b0;

    logic [NB-1:0] obs_stb;
    logic [15:0]   obs_adr;
    logic          obs_err, obs_irq;
    logic [31:0]   obs_dat;
    time           obs_time, t_req;

    logic [31:0] ref_mem [int];
    logic [31:0] bank_mem [int];

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] want);
        n_vec++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h at %0t",
                     name, act, want, $time);
        end
    endtask

    function automatic logic [31:0] seed_word(input int key);
        return 32'(key) * 32'h0001_0193 ^ 32'hA5A5_0000;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old,
                                          input logic [31:0] nw,
                                          input logic [3:0] s);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++)
            if (s[b]) r[b*8 +: 8] = nw[b*8 +: 8];
        return r;
    endfunction

    function automatic logic [31:0] ref_rd(input int key);
        return ref_mem.exists(key) ? ref_mem[key] : seed_word(key);
    endfunction

    function automatic logic [31:0] bank_rd(input int key);
        return bank_mem.exists(key) ? bank_mem[key] : seed_word(key);
    endfunction

    function automatic int lat_seen();
        return int'((obs_time - t_req) / 10);
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            chk("bank_stb", b_stb, exp_stb);
            chk("bank_cyc", b_cyc, exp_cyc);
            chk("ack", ack, exp_ack);
            chk("err", err, exp_err);
            chk("err_irq", irq, exp_err);
            chk("rdata", rdat, exp_dat);
            if (exp_cyc) begin
                chk("bank_adr", b_adr, exp_badr);
                chk("bank_dat", b_dat, exp_bdat);
                chk("bank_sel", b_sel, exp_bsel);
                chk("bank_we", b_we, exp_bwe);
            end
            if (b_stb != '0) begin
                obs_stb = obs_stb | b_stb;
                obs_adr = b_adr;
            end
            if (ack || err) begin
                obs_dat  = rdat;
                obs_err  = err;
                obs_irq  = irq;
                obs_time = $time;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_exp();
        exp_stb = '0;
        exp_cyc = 1'b0;
        exp_ack = 1'b0;
        exp_err = 1'b0;
    endtask

    task automatic drive_banks(input logic [1:0] idx, input bit all);
        b_rdat = {$urandom, $urandom, $urandom};
        b_ack  = '0;
        for (int k = 0; k < NB; k++)
            if (k != int'(idx) && (all || $urandom_range(0, 3) == 0))
                b_ack[k] = 1'b1;
    endtask

    // lat: bank ack delay after its strobe (-1 never); ab: cycle to drop cyc
    task automatic xact(input logic w, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] s,
                        input int lat, input int ab, input bit all);
        logic [1:0] idx;
        int key, bkey, t, outcome;
        idx = a[AW +: IW];
        key = int'(idx) * 65536 + int'({a[15:2], 2'b00});
        obs_stb = '0; obs_adr = '0; obs_err = 1'b0; obs_irq = 1'b0;
        obs_dat = '0; obs_time = 0; t_req = $time;
        stb = 1'b1; cyc = 1'b1; we = w; adr = a; wdat = d; sel = s;
        b_ack = '0;
        idle_exp();
        outcome = (int'(idx) < NB) ? 0 : 2;
        t = 0;
        while (outcome == 0) begin
            step();
            t++;
            exp_stb = 3'b001 << idx; exp_cyc = 1'b1;
            exp_badr = a[15:0]; exp_bdat = d;
            exp_bsel = s; exp_bwe = w;
            drive_banks(idx, all);
            if (t == ab) begin
                stb = 1'b0; cyc = 1'b0; outcome = 3;
            end else if (t == lat + 1) begin
                b_ack[idx] = 1'b1;
                bkey = int'(idx) * 65536 + int'({b_adr[15:2], 2'b00});
                if (w) bank_mem[bkey] = merge(bank_rd(bkey), b_dat, b_sel);
                else b_rdat[idx*32 +: 32] = bank_rd(bkey);
                outcome = 1;
            end else if (TO > 0 && t == TO) begin
                outcome = 2;
            end else if (t > 500) begin
                n_vec++; n_bad++;
                $display("FAIL xact_bound: no completion after %0d cycles", t);
                stb = 1'b0; cyc = 1'b0; outcome = 3;
            end
        end
        step();
        b_ack = '0;
        idle_exp();
        if (outcome == 1) begin
            exp_ack = 1'b1;
            exp_dat = w ? 32'h0 : ref_rd(key);
            if (w) ref_mem[key] = merge(ref_rd(key), d, s);
        end else if (outcome == 2) begin
            exp_err = 1'b1;
            exp_dat = 32'h0;
        end
        if (outcome != 3) begin
            step();
            idle_exp();
            stb = 1'b0; cyc = 1'b0;
        end
    endtask

    initial begin
        stb = 0; cyc = 0; we = 0; sel = 0; wdat = 0; adr = 0;
        b_ack = '0; b_rdat = '0;
        step(); step();
        chk("rst_stb", b_stb, 0);
        chk("rst_ack", {ack, err, irq, b_cyc}, 0);
        chk("rst_dat", rdat, 0);
        rst_n = 1'b1;
        chk_en = 1'b1;

        xact(1, 32'h0001_0010, 32'hDEADBEEF, 4'hF, 1, -1, 0);
        chk("t1_stb", obs_stb, 3'b010);
        chk("t1_adr", obs_adr, 16'h0010);
        chk("t1_wr_lat", lat_seen(), 3);
        xact(0, 32'h0001_0010, 32'h0, 4'hF, 1, -1, 0);
        chk("t1_rd_dat", obs_dat, 32'hDEADBEEF);
        chk("t1_rd_lat", lat_seen(), 3);

        xact(0, 32'h0003_0000, 32'h0, 4'hF, 0, -1, 0);
        chk("t2_err", obs_err, 1);
        chk("t2_irq", obs_irq, 1);
        chk("t2_stb", obs_stb, 0);
        chk("t2_dat", obs_dat, 0);
        chk("t2_lat", lat_seen(), 1);

`ifdef WB_SRAM_TIMEOUT_EN
        xact(0, 32'h0002_0008, 32'h0, 4'hF, -1, -1, 0);
        chk("t3_to_err", obs_err, 1);
        chk("t3_to_lat", lat_seen(), 9);
        xact(0, 32'h0002_0008, 32'h0, 4'hF, 7, -1, 0);
        chk("t3_edge_err", obs_err, 0);
        chk("t3_edge_lat", lat_seen(), 9);
`endif

        xact(0, 32'h0002_0004, 32'h0, 4'hF, 5, 2, 0);
        chk("t4_stb", obs_stb, 3'b100);
        chk("t4_no_resp", obs_time, 0);
        xact(0, 32'h0002_0004, 32'h0, 4'hF, 1, -1, 0);
        chk("t4_next_lat", lat_seen(), 3);

        stb = 1; cyc = 1; we = 0; adr = 32'h0000_0040; sel = 4'hF;
        idle_exp();
        step();
        exp_stb = 3'b001; exp_cyc = 1'b1; exp_badr = 16'h0040;
        exp_bdat = wdat; exp_bsel = 4'hF; exp_bwe = 1'b0;
        step();
        #2;
        rst_n = 1'b0;
        idle_exp();
        exp_dat = 32'h0;
        #1;
        chk("t5_stb", b_stb, 0);
        chk("t5_flags", {ack, err, irq, b_cyc, b_we}, 0);
        chk("t5_latch", {b_adr, b_sel, b_dat, rdat}, 0);
        stb = 0; cyc = 0;
        step(); step();
        rst_n = 1'b1;
        xact(0, 32'h0000_0040, 32'h0, 4'hF, 2, -1, 0);
        chk("t5_after_lat", lat_seen(), 4);

        xact(0, 32'h0000_0020, 32'h0, 4'hF, 3, -1, 1);
        chk("t6_lat", lat_seen(), 5);

        for (int i = 0; i < 300; i++) begin
            logic [31:0] a;
            int lat, ab;
            a = $urandom;
            a[17:16] = 2'($urandom_range(0, 3));
            a[15:0] = 16'($urandom_range(0, 15)) << 2;
            lat = $urandom_range(0, 5);
            if (TO > 0 && $urandom_range(0, 9) == 0) lat = -1;
            ab = -1;
            if (lat >= 1 && $urandom_range(0, 9) == 0)
                ab = $urandom_range(1, lat);
            xact(1'($urandom_range(0, 1)), a, $urandom,
                 4'($urandom_range(1, 15)), lat, ab, 0);
            repeat ($urandom_range(0, 2)) step();
        end

        step();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
